// File: rtl/wbu_retire.sv
// Writeback/retire stage: picks the writeback value, buffers it in an in-order FIFO,
// and drains it to the register-file port. Optional forwarding search under WBU_FWD_EN.
module wbu_retire #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rd_data,
  input  logic [1:0]      in_result_src,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd,
  output logic            rf_wr_en,
  input  logic            rf_wr_ready,
  output logic [4:0]      rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [63:0]     retire_cnt,
  input  logic [4:0]      fwd_rs,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage: datapath only, never reset; visibility is governed by count_q.
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic            wr_q   [DEPTH];
  logic [4:0]      rd_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      retire_q, retire_d;

  logic            head_valid;
  logic            full;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] in_data;
  logic            in_wr;

  always_comb begin
    in_data = '0;
    case (in_result_src)
      2'b00:   in_data = in_alu_result;
      2'b01:   in_data = in_mem_rd_data;
      2'b10:   in_data = in_pc + XLEN'(4);
      default: in_data = '0;
    endcase
  end

  assign in_wr      = in_reg_write && (in_rd != 5'd0);
  assign head_valid = (count_q != '0);
  assign full       = (count_q == FULL_CNT);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign pop        = head_valid && (!wr_q[head_q] || rf_wr_ready);

  // Head outputs are masked when empty so stale entry contents never leak out.
  assign rf_wr_en     = head_valid && wr_q[head_q];
  assign rf_wr_addr   = head_valid ? rd_q[head_q]   : 5'd0;
  assign rf_wr_data   = head_valid ? data_q[head_q] : '0;
  assign commit_valid = pop;
  assign commit_pc    = head_valid ? pc_q[head_q]   : '0;
  assign retire_cnt   = retire_q;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    retire_d = retire_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop) begin
      head_d   = head_q + PTR_W'(1);
      retire_d = retire_q + 64'd1;
    end
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      retire_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      retire_q <= retire_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q]   <= in_pc;
      data_q[tail_q] <= in_data;
      wr_q[tail_q]   <= in_wr;
      rd_q[tail_q]   <= in_rd;
    end
  end

`ifdef WBU_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so the youngest matching entry overrides earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && wr_q[fwd_idx] &&
          (rd_q[fwd_idx] == fwd_rs) && (fwd_rs != 5'd0)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end
`else
  logic fwd_rs_unused;

  assign fwd_rs_unused = ^fwd_rs;
  assign fwd_hit       = 1'b0;
  assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_wbu_retire.sv
// Directed bench for wbu_retire: reset, result select, rd=0, backpressure,
// forwarding (either build) and reset while entries are buffered.
module tb_wbu_retire;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_mem_rd_data;
  logic [1:0]      in_result_src;
  logic            in_reg_write;
  logic [4:0]      in_rd;
  logic            rf_wr_en;
  logic            rf_wr_ready;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [63:0]     retire_cnt;
  logic [4:0]      fwd_rs;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wbu_retire #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_alu_result(in_alu_result), .in_mem_rd_data(in_mem_rd_data),
    .in_result_src(in_result_src), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .rf_wr_en(rf_wr_en), .rf_wr_ready(rf_wr_ready), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .retire_cnt(retire_cnt), .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [1:0] src,
                       input logic rw, input logic [4:0] rd);
    in_valid = 1'b1; in_pc = pc; in_alu_result = alu; in_mem_rd_data = mem;
    in_result_src = src; in_reg_write = rw; in_rd = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_alu_result = '0; in_mem_rd_data = '0;
    in_result_src = 2'b00; in_reg_write = 1'b0; in_rd = '0; rf_wr_ready = 1'b1; fwd_rs = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", rf_wr_en); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rst_commit got %b want 0", commit_valid); end
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL rst_fwd_hit got %b want 0", fwd_hit); end
    checks++; if ({rf_wr_addr, rf_wr_data, commit_pc} !== 69'd0) begin errors++;
      $display("FAIL rst_head got addr=%h data=%h pc=%h want 0", rf_wr_addr, rf_wr_data, commit_pc); end
    checks++; if (retire_cnt !== 64'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", retire_cnt); end
  endtask

  task automatic test_load();
    offer(32'h0000_1000, 32'hDEAD_BEEF, 32'hFFFF_FF80, 2'b01, 1'b1, 5'd5);
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL load_wr_en got %b want 1", rf_wr_en); end
    checks++; if (rf_wr_addr !== 5'd5) begin errors++; $display("FAIL load_addr got %0d want 5", rf_wr_addr); end
    checks++; if (rf_wr_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL load_data got %h want ffffff80", rf_wr_data); end
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL load_commit got %b want 1", commit_valid); end
    checks++; if (commit_pc !== 32'h0000_1000) begin errors++; $display("FAIL load_pc got %h want 00001000", commit_pc); end
    step();
    checks++; if (retire_cnt !== 64'd1) begin errors++; $display("FAIL load_cnt got %0d want 1", retire_cnt); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL load_empty got %b want 0", rf_wr_en); end
  endtask

  task automatic test_jal();
    offer(32'hFFFF_FFFC, 32'h1111_1111, 32'h2222_2222, 2'b10, 1'b1, 5'd1);
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (rf_wr_data !== 32'h0000_0000) begin errors++; $display("FAIL jal_data got %h want 00000000", rf_wr_data); end
    checks++; if (rf_wr_addr !== 5'd1) begin errors++; $display("FAIL jal_addr got %0d want 1", rf_wr_addr); end
    checks++; if (commit_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jal_pc got %h want fffffffc", commit_pc); end
    step();
    checks++; if (retire_cnt !== 64'd2) begin errors++; $display("FAIL jal_cnt got %0d want 2", retire_cnt); end
  endtask

  task automatic test_rd0();
    rf_wr_ready = 1'b0;
    offer(32'h0000_2000, 32'h0000_1234, 32'h0, 2'b00, 1'b1, 5'd0);
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL rd0_wr_en got %b want 0", rf_wr_en); end
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL rd0_commit got %b want 1", commit_valid); end
    step();
    checks++; if (retire_cnt !== 64'd3) begin errors++; $display("FAIL rd0_cnt got %0d want 3", retire_cnt); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rd0_empty got %b want 0", commit_valid); end
  endtask

  task automatic test_back_to_back();
    rf_wr_ready = 1'b0;
    offer(32'h100, 32'hA0, 32'h0, 2'b00, 1'b1, 5'd10);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b want 1", in_ready); end
    step();
    offer(32'h104, 32'hA1, 32'h0, 2'b00, 1'b1, 5'd11);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
    step();
    offer(32'h108, 32'hA2, 32'h0, 2'b00, 1'b1, 5'd12);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b want 0", in_ready); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL bp_stall_commit got %b want 0", commit_valid); end
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full2 got %b want 0", in_ready); end
    checks++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd10, 32'hA0}) begin errors++;
      $display("FAIL bp_head_hold got en=%b addr=%0d data=%h want en=1 addr=10 data=a0", rf_wr_en, rf_wr_addr, rf_wr_data); end
    rf_wr_ready = 1'b1;
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL bp_pop0 got %b want 1", commit_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_on_pop got %b want 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b want 1", in_ready); end
    checks++; if ({commit_valid, rf_wr_addr, rf_wr_data, commit_pc} !== {1'b1, 5'd11, 32'hA1, 32'h104}) begin errors++;
      $display("FAIL bp_pop1 got v=%b addr=%0d data=%h pc=%h want v=1 addr=11 data=a1 pc=104", commit_valid, rf_wr_addr, rf_wr_data, commit_pc); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if ({commit_valid, rf_wr_addr, rf_wr_data, commit_pc} !== {1'b1, 5'd12, 32'hA2, 32'h108}) begin errors++;
      $display("FAIL bp_pop2 got v=%b addr=%0d data=%h pc=%h want v=1 addr=12 data=a2 pc=108", commit_valid, rf_wr_addr, rf_wr_data, commit_pc); end
    step();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", commit_valid); end
    checks++; if (retire_cnt !== 64'd6) begin errors++; $display("FAIL bp_cnt got %0d want 6", retire_cnt); end
  endtask

  task automatic test_forward();
    rf_wr_ready = 1'b0;
    offer(32'h200, 32'h11, 32'h0, 2'b00, 1'b1, 5'd7);
    step();
    offer(32'h204, 32'h22, 32'h0, 2'b00, 1'b1, 5'd7);
    step();
    in_valid = 1'b0;
    fwd_rs = 5'd7;
    #1;
`ifdef WBU_FWD_EN
    checks++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h22}) begin errors++;
      $display("FAIL fwd_young got hit=%b data=%h want hit=1 data=22", fwd_hit, fwd_data); end
    fwd_rs = 5'd3;
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss got %b want 0", fwd_hit); end
`else
    checks++; if ({fwd_hit, fwd_data} !== 33'd0) begin errors++;
      $display("FAIL fwd_off got hit=%b data=%h want 0", fwd_hit, fwd_data); end
`endif
    fwd_rs = 5'd0;
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_rs0 got %b want 0", fwd_hit); end
  endtask

  task automatic test_reset_buffered();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rb_pre_full got %b want 0", in_ready); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rb_ready got %b want 1", in_ready); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rb_commit got %b want 0", commit_valid); end
    checks++; if (retire_cnt !== 64'd0) begin errors++; $display("FAIL rb_cnt got %0d want 0", retire_cnt); end
    rf_wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({rf_wr_en, commit_valid} !== 2'b00) begin errors++;
        $display("FAIL rb_no_write cyc%0d got en=%b commit=%b want 0", i, rf_wr_en, commit_valid); end
      step();
    end
    checks++; if (retire_cnt !== 64'd0) begin errors++; $display("FAIL rb_cnt_end got %0d want 0", retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_jal();
    test_rd0();
    test_back_to_back();
    test_forward();
    test_reset_buffered();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wbu_retire.md
# wbu_retire

Writeback/retire stage directly downstream of the load/store unit. It accepts one completed instruction per cycle over a valid/ready handshake and selects the writeback value: ALU result, load data from the LSU, or PC+4. Selected results are buffered in a small in-order FIFO and drained to the register-file write port under that port's backpressure. Each drain raises a commit pulse for difftest and increments a 64-bit retire counter.

## Interface
- XLEN, 32, datapath width; equals REG_WIDTH
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream (MEM) holds a completed instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_alu_result  in  XLEN  ALUResultM
- in_mem_rd_data  in  XLEN  LSU load data, already sign/zero extended
- in_result_src  in  2  00 ALU, 01 mem, 10 PC+4, 11 zero
- in_reg_write  in  1  instruction writes rd
- in_rd  in  5  destination register
- rf_wr_en  out  1  register-file write request
- rf_wr_ready  in  1  register file accepts the write this cycle
- rf_wr_addr  out  5  write address
- rf_wr_data  out  XLEN  write data
- commit_valid  out  1  head instruction retires this cycle
- commit_pc  out  XLEN  PC of retiring instruction
- retire_cnt  out  64  retired-instruction count
- fwd_rs  in  5  forwarding lookup address
- fwd_hit  out  1  a buffered entry holds the newest value for fwd_rs
- fwd_data  out  XLEN  that value

## Operation
- Entry fields: pc, data, wr (= in_reg_write && in_rd≠0), rd. `data` is muxed at the input, before the entry is written.
- PC+4 is computed as in_pc+32'd4 and wraps modulo 2^XLEN.
- in_ready = !full. It is registered state only; in_valid is not in its path.
- Push condition: in_valid && in_ready. Pushes go to the tail.
- Head outputs, taken from entry registers:
  - rf_wr_en = head_valid && head.wr
  - rf_wr_addr = head.rd
  - rf_wr_data = head.data
- Pop condition: head_valid && (!head.wr || rf_wr_ready). Entries that do not write pop without waiting for rf_wr_ready.
- commit_valid = pop condition; commit_pc = head.pc.
- retire_cnt increments by 1 on each pop and wraps from 2^64−1 to 0.
- Occupancy counter runs 0..DEPTH. Push and pop in the same cycle leave it unchanged. Pointers wrap modulo DEPTH.
- When full, in_ready=0 even if a pop occurs that cycle. This keeps ready-to-ready combinational paths out of the design.
- When empty: rf_wr_en=0 and commit_valid=0. An entry pushed in cycle N is never visible on the outputs in cycle N.
- fwd_hit/fwd_data (see Configuration):
  - search valid entries with wr=1 and rd==fwd_rs; the youngest match wins
  - fwd_rs==0 never hits
  - the same-cycle input is not searched

## Timing
- Reset, when rst_n=0 at a rising edge:
  - FIFO empties, pointers and retire_cnt clear to 0
  - in_ready=1 from the next cycle
  - rf_wr_en, commit_valid, fwd_hit=0; rf_wr_addr, rf_wr_data, commit_pc=0
- Reset mid-drain discards buffered entries with no commit.
- Latency: accept at edge N, then rf_wr_en/commit_valid at the earliest during cycle N+1.
- Throughput: 1 retire per cycle while rf_wr_ready=1.
- rf_wr_ready low stalls the head: all head outputs hold stable until the pop.
- Upstream must hold in_* stable while in_valid && !in_ready.

## Configuration
- WBU_FWD_EN defined: forwarding search is compiled in as described in Operation.
- WBU_FWD_EN undefined: fwd_hit ties to 0 and fwd_data to 0; fwd_rs is ignored and the search logic is absent.
- All other behaviour is identical in both builds.

## Test plan
- Single load: in_result_src=01, in_mem_rd_data=0xFFFFFF80, in_rd=5, rf_wr_ready=1.
  - Required: cycle after accept, rf_wr_en=1, addr=5, data=0xFFFFFF80; commit_valid=1; retire_cnt becomes 1.
- JAL-type: in_result_src=10, in_pc=0xFFFFFFFC.
  - Required: rf_wr_data=0x00000000 (wrap).
- in_rd=0 with reg_write=1: rf_wr_en=0, commit_valid=1, count increments.
- Backpressure: rf_wr_ready=0 while 3 writes are offered back-to-back.
  - Required: in_ready drops after 2 accepts; head held stable.
  - Then release rf_wr_ready. Required: retires in order at 1/cycle, and in_ready rises the cycle after the first pop.
- Forwarding (WBU_FWD_EN), run with rf_wr_ready=0:
  - Buffer rd=7 with data 0x11, then rd=7 with data 0x22. Required: fwd_rs=7 gives hit=1, data=0x22.
  - fwd_rs=0: hit=0.
  - Without WBU_FWD_EN: hit=0 always.
- Reset with 2 entries buffered and rf_wr_ready=0:
  - Required: next cycle in_ready=1, commit_valid=0, retire_cnt=0, and no write is emitted afterwards.
